// File: rtl/tdm_mux8.sv
// rtl/tdm_mux8.sv - time-division 8:1 multiplexer sending one slot-tagged word per clock
// Define TDM_MUX8_PARITY_EN to append a ninth XOR-parity slot to every frame.
module tdm_mux8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [8*W-1:0] in,
  input  logic           start,
  output logic           ack,
  output logic [W-1:0]   out,
  output logic [2:0]     s,
  output logic           valid,
  output logic           sof,
  output logic           eof,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;

  state_t       state, state_n;
  logic [2:0]   slot, slot_n, slot_inc;
  logic [W-1:0] shadow   [8];
  logic [W-1:0] shadow_n [8];
  logic [W-1:0] in_word  [8];
  logic [W-1:0] out_q, out_n;
  logic [2:0]   s_q, s_n;
  logic         valid_q, valid_n;
  logic         sof_q, sof_n;
  logic         eof_q, eof_n;
  logic         busy_q, busy_n;
  logic         capture, finish;

  always_comb begin
    for (int k = 0; k < 8; k++) in_word[k] = in[k*W +: W];
  end

  assign slot_inc = slot + 3'd1;

`ifdef TDM_MUX8_PARITY_EN
  logic [W-1:0] parity_word;

  always_comb begin
    parity_word = '0;
    for (int k = 0; k < 8; k++) parity_word = parity_word ^ shadow[k];
  end
`endif

  // The output registers always hold the word being presented; each enabled
  // edge loads the next word, so a capture shows slot 0 on the following cycle.
  always_comb begin
    state_n  = state;
    slot_n   = slot;
    shadow_n = shadow;
    out_n    = out_q;
    s_n      = s_q;
    valid_n  = valid_q;
    sof_n    = sof_q;
    eof_n    = eof_q;
    capture  = 1'b0;
    finish   = 1'b0;

    if (en) begin
      case (state)
        IDLE: capture = start;
        SEND: begin
          if (slot != 3'd7) begin
            slot_n  = slot_inc;
            out_n   = shadow[slot_inc];
            s_n     = slot_inc;
            valid_n = 1'b1;
            sof_n   = 1'b0;
`ifdef TDM_MUX8_PARITY_EN
            eof_n   = 1'b0;
`else
            eof_n   = (slot_inc == 3'd7);
`endif
          end else begin
`ifdef TDM_MUX8_PARITY_EN
            state_n = PARITY;
            out_n   = parity_word;
            s_n     = 3'd7;
            valid_n = 1'b1;
            sof_n   = 1'b0;
            eof_n   = 1'b1;
`else
            capture = start;
            finish  = !start;
`endif
          end
        end
`ifdef TDM_MUX8_PARITY_EN
        PARITY: begin
          capture = start;
          finish  = !start;
        end
`endif
        default: finish = 1'b1;
      endcase

      if (capture) begin
        for (int k = 0; k < 8; k++) shadow_n[k] = in_word[k];
        state_n = SEND;
        slot_n  = 3'd0;
        out_n   = in_word[0];
        s_n     = 3'd0;
        valid_n = 1'b1;
        sof_n   = 1'b1;
        eof_n   = 1'b0;
      end

      // out and s keep their last values while idle
      if (finish) begin
        state_n = IDLE;
        slot_n  = 3'd0;
        valid_n = 1'b0;
        sof_n   = 1'b0;
        eof_n   = 1'b0;
      end
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      slot    <= 3'd0;
      out_q   <= '0;
      s_q     <= 3'd0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < 8; k++) shadow[k] <= '0;
    end else begin
      state   <= state_n;
      slot    <= slot_n;
      out_q   <= out_n;
      s_q     <= s_n;
      valid_q <= valid_n;
      sof_q   <= sof_n;
      eof_q   <= eof_n;
      busy_q  <= busy_n;
      shadow  <= shadow_n;
    end
  end

  // Strobes are masked by en so a frozen cycle never looks like a word.
  assign ack   = capture;
  assign out   = out_q;
  assign s     = s_q;
  assign valid = valid_q & en;
  assign sof   = sof_q & en;
  assign eof   = eof_q & en;
  assign busy  = busy_q;

endmodule

// File: tb/tb_tdm_mux8.sv
// tb/tb_tdm_mux8.sv - self-checking bench for tdm_mux8 (frame-queue model plus directed literals)
`timescale 1ns/1ps
module tb_tdm_mux8;
  localparam int W = 4;
`ifdef TDM_MUX8_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           en = 1'b0;
  logic           start = 1'b0;
  logic [8*W-1:0] din = '0;
  logic           ack, valid, sof, eof, busy;
  logic [W-1:0]   dout;
  logic [2:0]     s;
  int             checks = 0;
  int             failures = 0;

  tdm_mux8 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .start(start), .ack(ack),
    .out(dout), .s(s), .valid(valid), .sof(sof), .eof(eof), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  // Model: a queue of words still to be presented; the front is on the lane now.
  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   slot;
    logic         sof;
    logic         eof;
  } rec_t;

  rec_t         pend[$];
  logic [W-1:0] last_out = '0;
  logic [2:0]   last_s = '0;

  always @(negedge clk) begin
    if (!rst_n) begin : in_reset
      pend.delete();
      last_out = '0;
      last_s   = '0;
      chk("rst_out", 32'(dout), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_sof", 32'(sof), 32'd0);
      chk("rst_eof", 32'(eof), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin : running
      rec_t         r;
      logic [W-1:0] par;
      bit           present, at_last, exp_ack;
      present = pend.size() > 0;
      if (present) begin
        last_out = pend[0].data;
        last_s   = pend[0].slot;
      end
      at_last = present ? pend[0].eof : 1'b1;
      exp_ack = en && start && at_last;
      chk("m_ack", 32'(ack), 32'(exp_ack));
      chk("m_out", 32'(dout), 32'(last_out));
      chk("m_s", 32'(s), 32'(last_s));
      chk("m_valid", 32'(valid), 32'(en && present));
      chk("m_sof", 32'(sof), 32'(en && (present ? pend[0].sof : 1'b0)));
      chk("m_eof", 32'(eof), 32'(en && (present ? pend[0].eof : 1'b0)));
      chk("m_busy", 32'(busy), 32'(present));
      if (en && present) void'(pend.pop_front());
      if (exp_ack) begin
        par = '0;
        for (int k = 0; k < 8; k++) begin
          r.data = din[k*W +: W];
          r.slot = 3'(k);
          r.sof  = (k == 0);
`ifdef TDM_MUX8_PARITY_EN
          r.eof  = 1'b0;
`else
          r.eof  = (k == 7);
`endif
          par = par ^ r.data;
          pend.push_back(r);
        end
`ifdef TDM_MUX8_PARITY_EN
        r.data = par;
        r.slot = 3'd7;
        r.sof  = 1'b0;
        r.eof  = 1'b1;
        pend.push_back(r);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [8*W-1:0] f;
    logic [7:0]     pat;
    int             acks, sofs, nval, run, maxrun;
    bit             froze;

    #2 rst_n = 1'b0;
    repeat (2) step();
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out", 32'(dout), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    step();
    step();
    chk("idle_no_start", 32'(busy), 32'd0);

    // single frame: channel k carries bit k of 1010_0110
    pat = 8'b1010_0110;
    for (int k = 0; k < 8; k++) f[k*W +: W] = {{(W-1){1'b0}}, pat[k]};
    din = f;
    start = 1'b1;
    #1 chk("single_ack", 32'(ack), 32'd1);
    step();
    start = 1'b0;
    din = '1;
    for (int k = 0; k < 8; k++) begin
      chk("single_out", 32'(dout), 32'(pat[k]));
      chk("single_s", 32'(s), 32'(k));
      chk("single_sof", 32'(sof), 32'(k == 0));
`ifndef TDM_MUX8_PARITY_EN
      chk("single_eof", 32'(eof), 32'(k == 7));
`endif
      step();
    end
`ifdef TDM_MUX8_PARITY_EN
    step();
`endif
    chk("single_busy_drop", 32'(busy), 32'd0);

    // back-to-back: all-ones frame, then all-zeros frame with start held
    din = '1;
    start = 1'b1;
    acks = 0; sofs = 0; nval = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ack) begin
        acks++;
        if (acks == 2) begin
          chk("b2b_ack_slot", 32'(s), 32'd7);
          chk("b2b_ack_eof", 32'(eof), 32'd1);
        end
      end
      if (sof && valid) sofs++;
      if (valid) begin
        run++;
        nval++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (!start && !busy) break;
      step();
      if (acks >= 1) din = '0;
      if (acks >= 2) start = 1'b0;
    end
    chk("b2b_acks", 32'(acks), 32'd2);
    chk("b2b_sofs", 32'(sofs), 32'd2);
    chk("b2b_valid", 32'(nval), 32'(2*FL));
    chk("b2b_gapless", 32'(maxrun), 32'(2*FL));
    step();
    wait_idle("b2b_idle");

    // enable freeze while slot 4 is on the lane
    for (int k = 0; k < 8; k++) f[k*W +: W] = W'(8 + k);
    din = f;
    start = 1'b1;
    step();
    start = 1'b0;
    froze = 1'b0;
    nval = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid) nval++;
      if (!busy && nval > 0) break;
      if (!froze && valid && s == 3'd3) begin
        froze = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("frz_valid", 32'(valid), 32'd0);
          chk("frz_s", 32'(s), 32'd4);
          chk("frz_out", 32'(dout), 32'hC);
          if (i < 2) step();
        end
        step();
        en = 1'b1;
      end else begin
        step();
      end
    end
    chk("frz_seen", 32'(froze), 32'd1);
    chk("frz_count", 32'(nval), 32'(FL));
    wait_idle("frz_idle");

    // start pulsed mid-frame is ignored
    for (int k = 0; k < 8; k++) f[k*W +: W] = W'(3*k + 1);
    din = f;
    start = 1'b1;
    step();
    start = 1'b0;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack) acks++;
      if (!busy) break;
      step();
      start = (s == 3'd2);
    end
    start = 1'b0;
    chk("ign_acks", 32'(acks), 32'd0);
    wait_idle("ign_idle");

    // asynchronous reset during slot 3
    din = f;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (valid && s == 3'd3) break;
      step();
    end
    chk("rstmid_at_s3", 32'(s), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_out", 32'(dout), 32'd0);
    chk("rstmid_s", 32'(s), 32'd0);
    chk("rstmid_valid", 32'(valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rstmid_stay_idle", 32'(busy), 32'd0);
    chk("rstmid_no_valid", 32'(valid), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_s", 32'(s), 32'd0);
    chk("post_rst_out", 32'(dout), 32'd1);
    chk("post_rst_sof", 32'(sof), 32'd1);
    wait_idle("post_rst_idle");

`ifdef TDM_MUX8_PARITY_EN
    // parity of 1..8 is 8
    for (int k = 0; k < 8; k++) f[k*W +: W] = W'(k + 1);
    din = f;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("par_s7_eof", 32'(eof), 32'd0);
    chk("par_s7_out", 32'(dout), 32'h8);
    step();
    chk("par_out", 32'(dout), 32'h8);
    chk("par_s", 32'(s), 32'd7);
    chk("par_eof", 32'(eof), 32'd1);
    chk("par_valid", 32'(valid), 32'd1);
    wait_idle("par_idle");
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_mux8.md
# tdm_mux8

Time-division 8:1 multiplexer: the transmit-side counterpart of the 1:8 DeMUX. It captures eight parallel channel words as one frame and sends them one slot per clock on a single output lane. Each word is tagged with its 3-bit slot index `s`, so a downstream DeMUX driven by `s` and `valid` restores the original eight lanes. It sits between parallel channel sources and any serial lane or DeMUX-based receiver.

## Interface
Parameters:
- `W`, default 1: width of each channel word in bits (1..32).

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `en`, input, 1: global enable.
  - 0 freezes all state and forces `valid` = 0.
- `in`, input, 8*W: frame to send.
  - Channel k occupies `in[k*W +: W]`.
- `start`, input, 1: frame request; sampled only at a capture opportunity.
- `ack`, output, 1: combinational; high in the cycle `in` is captured.
- `out`, output, W: current slot data (registered).
- `s`, output, 3: current slot index (registered).
- `valid`, output, 1: `out` and `s` are meaningful this cycle.
- `sof`, output, 1: start of frame; high together with slot 0.
- `eof`, output, 1: end of frame; high with the last word of a frame.
- `busy`, output, 1: state is not IDLE.

## Operation
- Shadow register `buf` (8*W bits) holds the frame being sent. `in` may change freely after `ack`.
- State machine:
  - IDLE → SEND when `en && start`. `in` is captured into `buf`, `ack` = 1, slot counter = 0.
  - SEND, slot < 7: on each enabled cycle, drive `out` = `buf[slot]`, `s` = slot, `valid` = 1, then increment slot.
  - SEND, slot == 7, with `start` = 1: back-to-back. Capture the new `in` (`ack` = 1), wrap slot to 0, stay in SEND. No idle cycle between frames.
  - SEND, slot == 7, with `start` = 0: → IDLE.
  - In parity builds, the slot-7 decision moves to PARITY (see Configuration).
- Capture opportunities are IDLE, and the last data slot of a frame.
  - `start` asserted at any other time is ignored; it is not latched.
- `en` = 0 in any state:
  - slot, state and `buf` hold;
  - `valid`, `sof`, `eof` = 0;
  - `out` and `s` hold their last values;
  - `ack` = 0.
- When `en` returns to 1, sending resumes at the held slot. No data is lost or repeated.
- Slot counter is 3 bits and wraps 7 → 0 naturally.

## Timing
- Reset values (asynchronous, applied on `rst_n` = 0 at any time, including mid-frame):
  - `out` = 0, `s` = 0, `valid` = 0, `sof` = 0, `eof` = 0, `busy` = 0;
  - `buf` = 0, state IDLE, slot 0.
  - A partial frame is discarded.
- Latency: `ack` in cycle N → slot 0 on `out` with `valid` = 1 and `sof` = 1 in cycle N+1.
- A frame occupies 8 consecutive enabled cycles (9 with parity).
- Throughput with `start` held high: one word per clock, continuously.
- `busy` is registered. It is 1 from cycle N+1 through the last slot cycle, and drops the cycle after the final `eof` when no new capture occurred.
- `eof` goes high with slot 7 (or with the parity slot when parity is compiled in).

## Configuration
- Macro: `TDM_MUX8_PARITY_EN`.
- Defined:
  - After slot 7, state PARITY lasts one enabled cycle.
  - Outputs in PARITY: `out` = XOR of all eight `buf` words (bitwise, W bits), `s` = 7, `valid` = 1, `eof` = 1.
  - Slot 7 has `eof` = 0.
  - The back-to-back capture decision moves from slot 7 to the PARITY cycle.
- Not defined:
  - No PARITY state; frame length is 8.
  - `eof` is high on slot 7.
  - Capture decision is at slot 7.

## Test plan
- **Reset mid-frame:** start a frame, pull `rst_n` low during slot 3 → all outputs 0 immediately. After release, the block stays in IDLE until the next `start`.
- **Single frame:** W = 1, `in` = 8'b1010_0110, one-cycle `start` pulse → `ack` in cycle N. Cycles N+1..N+8 give `out` = 0,1,1,0,0,1,0,1 with `s` = 0..7, `sof` at `s` = 0, `eof` at `s` = 7 (no-parity build), then `busy` = 0.
- **Back-to-back:** `start` held high, `in` = 8'hFF then 8'h00 → 16 consecutive `valid` cycles with no gap. `ack` at the first capture and at the first frame's slot 7. `sof` is seen twice.
- **Enable freeze:** drop `en` for 3 cycles while `s` = 4 → `valid` = 0 for those 3 cycles. Resumes with `s` = 4 and the same data; total 8 valid words.
- **Ignored start:** pulse `start` during slot 2 and deassert before slot 7 → no `ack`, and the block returns to IDLE after slot 7.
- **Parity build:** W = 4, channels 1..8 (4'h1..4'h8) → slot 8 output has `out` = 4'h8, `s` = 7, `eof` = 1; slot 7 has `eof` = 0.
